// File: rtl/sat_pkg.sv
// Shared types and widths for the clause store: literal/clause/row widths and the loader state encoding.
package sat_pkg;
  localparam int NUM_CLAUSES           = 64;
  localparam int VAR_ID_BITS           = 8;
  localparam int NUM_CLAUSES_PER_CYCLE = 16;
  localparam int NUM_VARS_PER_CLAUSE   = 3;
  localparam int CLAUSE_BITS = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE;
  localparam int ROW_BITS    = CLAUSE_BITS * NUM_CLAUSES_PER_CYCLE;

  typedef struct packed {
    logic                   sign;
    logic [VAR_ID_BITS-1:0] id;
  } literal_t;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, DONE, ERROR} loader_state_e;
endpackage

// File: rtl/clause_memory_loader.sv
// Packs streamed clauses into clause-memory rows and issues one write per row; reports done/err.
// Build option CLAUSE_PAD_EN: a short final row is zero-padded and written instead of flagging an error.
module clause_memory_loader #(
  parameter int NUM_CLAUSES           = 64,
  parameter int VAR_ID_BITS           = 8,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter int NUM_VARS_PER_CLAUSE   = 3,
  localparam int NUM_ROWS    = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int PTR_BITS    = $clog2(NUM_ROWS),
  localparam int CLAUSE_BITS = (VAR_ID_BITS + 1) * NUM_VARS_PER_CLAUSE,
  localparam int ROW_BITS    = CLAUSE_BITS * NUM_CLAUSES_PER_CYCLE,
  localparam int CNT_BITS    = $clog2(NUM_CLAUSES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CLAUSE_BITS-1:0] in_clause,
  input  logic                   in_last,
  output logic                   wr_en,
  output logic [PTR_BITS-1:0]    wr_row,
  output logic [ROW_BITS-1:0]    wr_data,
  output logic [CNT_BITS-1:0]    clauses_loaded,
  output logic                   done,
  output logic                   err
);
  import sat_pkg::*;

  localparam int SLOT_BITS = $clog2(NUM_CLAUSES_PER_CYCLE);

  loader_state_e        state;
  logic [SLOT_BITS-1:0] slot;
  logic [PTR_BITS-1:0]  row;
  logic [ROW_BITS-1:0]  row_buf;
  logic                 last_seen;

  logic                 take;
  logic                 row_full;
  logic                 row_close;
  logic [ROW_BITS-1:0]  buf_next;

  // in_ready is registered and only ever high in FILL, so a handshake implies FILL.
  assign take     = in_valid & in_ready;
  assign row_full = (slot == SLOT_BITS'(NUM_CLAUSES_PER_CYCLE - 1));
`ifdef CLAUSE_PAD_EN
  assign row_close = take & (row_full | in_last);
`else
  assign row_close = take & row_full;
`endif

  always_comb begin
    buf_next = row_buf;
    buf_next[int'(slot) * CLAUSE_BITS +: CLAUSE_BITS] = in_clause;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      slot           <= '0;
      row            <= '0;
      row_buf        <= '0;
      last_seen      <= 1'b0;
      clauses_loaded <= '0;
      in_ready       <= 1'b0;
      wr_en          <= 1'b0;
      wr_row         <= '0;
      wr_data        <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else if (start) begin
      // Restart abandons any partly filled row without writing it.
      state          <= FILL;
      slot           <= '0;
      row            <= '0;
      row_buf        <= '0;
      last_seen      <= 1'b0;
      clauses_loaded <= '0;
      in_ready       <= 1'b1;
      wr_en          <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (take) begin
            row_buf        <= buf_next;
            slot           <= slot + SLOT_BITS'(1);
            clauses_loaded <= clauses_loaded + CNT_BITS'(1);
            last_seen      <= in_last;
            if (row_close) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              wr_en    <= 1'b1;
              wr_row   <= row;
              wr_data  <= buf_next;
            end else if (in_last) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        WRITE: begin
          wr_en <= 1'b0;
          if (row == PTR_BITS'(NUM_ROWS - 1) || last_seen) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= FILL;
            row      <= row + PTR_BITS'(1);
            slot     <= '0;
            row_buf  <= '0;
            in_ready <= 1'b1;
          end
        end
        IDLE, DONE, ERROR: ;
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          wr_en    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clause_memory_loader.sv
// Directed bench for clause_memory_loader: queue-based reference model checked every cycle plus literal row checks.
module tb_clause_memory_loader;
  import sat_pkg::*;

  localparam int CB    = CLAUSE_BITS;
  localparam int RB    = ROW_BITS;
  localparam int SLOTS = NUM_CLAUSES_PER_CYCLE;
  localparam int ROWS  = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [CB-1:0] in_clause = '0;
  logic          in_ready, wr_en, done, err;
  logic [1:0]    wr_row;
  logic [RB-1:0] wr_data;
  logic [6:0]    clauses_loaded;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  logic [RB-1:0] mem [ROWS];

  always #5 clk = ~clk;

  clause_memory_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_clause(in_clause), .in_last(in_last),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .clauses_loaded(clauses_loaded), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: the accepted-clause list since the last start, and what the outputs must show.
  logic [CB-1:0] acc[$];
  int            n = 0;
  bit            active = 0, e_done = 0, e_err = 0, wr_now = 0, wr_nxt = 0, last_seen = 0;
  logic [1:0]    e_row = '0;
  logic [RB-1:0] e_data = '0;

  function automatic logic [RB-1:0] build_row(input int r);
    logic [RB-1:0] d;
    d = '0;
    for (int k = 0; k < SLOTS; k++)
      if (r * SLOTS + k < acc.size()) d[k*CB +: CB] = acc[r * SLOTS + k];
    return d;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_wr_en", wr_en, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_count", clauses_loaded, 0);
      chk("rst_done_err", {done, err}, 0);
      acc.delete();
      n = 0; active = 0; e_done = 0; e_err = 0; wr_now = 0; last_seen = 0;
    end else begin
      chk("count", clauses_loaded, n);
      chk("wr_en", wr_en, wr_now);
      chk("in_ready", in_ready, active && !wr_now);
      chk("done", done, e_done);
      chk("err", err, e_err);
      if (wr_en) begin
        mem[wr_row] = wr_data;
        wr_cnt++;
        if (wr_now) begin
          chk("wr_row", wr_row, e_row);
          chk("wr_data", wr_data, e_data);
        end
      end
      wr_nxt = 0;
      if (start) begin
        acc.delete();
        n = 0; active = 1; e_done = 0; e_err = 0; last_seen = 0;
      end else if (wr_now) begin
        if (e_row == 2'(ROWS - 1) || last_seen) begin
          e_done = 1;
          active = 0;
        end
      end else if (active && in_valid) begin
        acc.push_back(in_clause);
        n++;
        last_seen = in_last;
        if (n % SLOTS == 0 || in_last) begin
`ifdef CLAUSE_PAD_EN
          wr_nxt = 1;
`else
          wr_nxt = (n % SLOTS == 0);
          if (!wr_nxt) begin
            e_err = 1;
            active = 0;
          end
`endif
          if (wr_nxt) begin
            e_row  = 2'((n - 1) / SLOTS);
            e_data = build_row((n - 1) / SLOTS);
          end
        end
      end
      wr_now = wr_nxt;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int v, input bit last);
    bit got;
    got = 0;
    in_valid = 1'b1; in_clause = CB'(v); in_last = last;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_clause = CB'($urandom);
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout: clause %0d not taken, in_ready=%0b want 1", v, in_ready);
    end
  endtask

  task automatic wait_end();
    bit hit;
    hit = 0;
    for (int t = 0; t < 100 && !hit; t++) begin
      @(posedge clk); #1;
      hit = done | err;
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL end_timeout: done=%0b err=%0b want one of them 1", done, err);
    end
  endtask

  task automatic clear_mem();
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
  endtask

  initial begin
    logic [RB-1:0] t1_rows [ROWS];
    logic [RB-1:0] exp_row;
    int base;

    repeat (2) @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_wr_data", wr_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);

    // 1: full load, clause i = i
    clear_mem();
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 64; i++) send(i, i == 63);
    wait_end();
    chk("t1_done", done, 1);
    chk("t1_count", clauses_loaded, 64);
    chk("t1_writes", wr_cnt - base, 4);
    chk("t1_r2_s5", mem[2][5*CB +: CB], 37);
    for (int r = 0; r < ROWS; r++) begin
      exp_row = '0;
      for (int k = 0; k < SLOTS; k++) exp_row[k*CB +: CB] = CB'(16 * r + k);
      chk($sformatf("t1_row%0d", r), mem[r], exp_row);
      t1_rows[r] = mem[r];
    end

    // 6: extra valid after DONE
    base = wr_cnt;
    in_valid = 1'b1; in_clause = CB'(999);
    repeat (8) @(posedge clk); #1;
    chk("t6_in_ready", in_ready, 0);
    in_valid = 1'b0;
    chk("t6_count", clauses_loaded, 64);
    chk("t6_writes", wr_cnt - base, 0);

    // 2: same load with random gaps, garbage on in_clause while idle
    clear_mem();
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 3)) begin
        in_clause = CB'($urandom);
        @(posedge clk); #1;
      end
      send(i, i == 63);
    end
    wait_end();
    chk("t2_done", done, 1);
    chk("t2_count", clauses_loaded, 64);
    chk("t2_writes", wr_cnt - base, 4);
    for (int r = 0; r < ROWS; r++) chk($sformatf("t2_row%0d", r), mem[r], t1_rows[r]);

    // 3: in_last on clause 19 (partial second row)
    clear_mem();
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 20; i++) send(i, i == 19);
    wait_end();
    chk("t3_count", clauses_loaded, 20);
`ifdef CLAUSE_PAD_EN
    chk("t3_done", done, 1);
    chk("t3_writes", wr_cnt - base, 2);
    chk("t3_r1_s3", mem[1][3*CB +: CB], 19);
    exp_row = '0;
    for (int k = 0; k < 4; k++) exp_row[k*CB +: CB] = CB'(16 + k);
    chk("t3_row1", mem[1], exp_row);
`else
    chk("t3_err", err, 1);
    chk("t3_done", done, 0);
    chk("t3_writes", wr_cnt - base, 1);
    chk("t3_row1_untouched", mem[1], 0);
`endif

    // 4: restart after 5 clauses
    clear_mem();
    pulse_start();
    for (int i = 0; i < 5; i++) send(200 + i, 1'b0);
    base = wr_cnt;
    pulse_start();
    chk("t4_count_cleared", clauses_loaded, 0);
    for (int i = 0; i < 16; i++) send(100 + i, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("t4_writes", wr_cnt - base, 1);
    chk("t4_count", clauses_loaded, 16);
    chk("t4_r0_s0", mem[0][0 +: CB], 100);
    chk("t4_r0_s15", mem[0][15*CB +: CB], 115);

    // 5: async reset mid-row
    pulse_start();
    for (int i = 0; i < 7; i++) send(300 + i, 1'b0);
    base = wr_cnt;
    reset_n = 1'b0;
    #1;
    chk("t5_wr_en", wr_en, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_count", clauses_loaded, 0);
    chk("t5_done_err", {done, err}, 0);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("t5_no_write", wr_cnt - base, 0);
    chk("t5_idle_ready", in_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
